// File: rtl/gray_decoder.sv
// gray_decoder: two-stage Gray-to-binary pipeline that classifies each
// decoded sample against the previous one and keeps a sticky error flag.
module gray_decoder #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             not_reset,
  input  logic             en,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clear,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid_out,
  output logic             step_up,
  output logic             step_down,
  output logic             hold,
  output logic             step_err,
  output logic             error
);

  typedef enum logic [1:0] {
    SYNC,
    TRACK,
    FAULT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] g1;
  logic             v1;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] last_bin;
  logic [WIDTH-1:0] delta;
  logic             up_d;
  logic             down_d;
  logic             hold_d;
  logic             err_d;
  logic             error_d;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      v1 <= 1'b0;
      g1 <= '0;
    end else begin
      v1 <= en;
      if (en) g1 <= gray_in;
    end
  end

  // Each binary bit is the parity of the Gray bits at and above it.
  always_comb begin
    b = '0;
    for (int i = 0; i < WIDTH; i++) begin
      b[i] = ^(g1 >> i);
    end
  end

  assign delta = b - last_bin;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) state_q <= SYNC;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (v1 && state_q == SYNC) state_d = TRACK;
    if (err_d)          state_d = FAULT;
    else if (err_clear) state_d = SYNC;
  end

  always_comb begin
    up_d   = 1'b0;
    down_d = 1'b0;
    hold_d = 1'b0;
    err_d  = 1'b0;
    if (v1 && state_q != SYNC) begin
      unique case (1'b1)
        (delta == '0):        hold_d = 1'b1;
        (delta == WIDTH'(1)): up_d   = 1'b1;
        (&delta):             down_d = 1'b1;
        default:              err_d  = 1'b1;
      endcase
    end
  end

  // A step error on the clearing edge wins over err_clear.
  assign error_d = err_d | (error & ~err_clear);

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      bin_out   <= '0;
      last_bin  <= '0;
      valid_out <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      hold      <= 1'b0;
      step_err  <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= v1;
      step_up   <= up_d;
      step_down <= down_d;
      hold      <= hold_d;
      step_err  <= err_d;
      error     <= error_d;
      if (v1) begin
        bin_out  <= b;
        last_bin <= b;
      end
    end
  end

endmodule

// File: tb/tb_gray_decoder.sv
// tb_gray_decoder: scoreboard bench driving a WIDTH=2 and a WIDTH=3
// decoder against a Gray-code reference model.
module tb_gray_decoder;

  typedef struct {
    int bin;
    int fl;
    int due;
  } exp_t;

  logic       clk = 1'b0;
  logic       not_reset;
  logic       en_s  [2];
  logic       clr_s [2];
  logic [1:0] gin0;
  logic [2:0] gin1;
  logic [1:0] bin0;
  logic [2:0] bin1;
  logic       vld [2];
  logic       up  [2];
  logic       dn  [2];
  logic       hd  [2];
  logic       se  [2];
  logic       er  [2];

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc_cnt = 0;
  int   W [2] = '{2, 3};
  bit   synced [2];
  int   last [2];
  bit   merr [2];
  bit   pend [2];
  int   pend_g [2];
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  gray_decoder #(.WIDTH(2)) dut0 (
    .clk(clk), .not_reset(not_reset), .en(en_s[0]), .gray_in(gin0),
    .err_clear(clr_s[0]), .bin_out(bin0), .valid_out(vld[0]),
    .step_up(up[0]), .step_down(dn[0]), .hold(hd[0]),
    .step_err(se[0]), .error(er[0])
  );

  gray_decoder #(.WIDTH(3)) dut1 (
    .clk(clk), .not_reset(not_reset), .en(en_s[1]), .gray_in(gin1),
    .err_clear(clr_s[1]), .bin_out(bin1), .valid_out(vld[1]),
    .step_up(up[1]), .step_down(dn[1]), .hold(hd[1]),
    .step_err(se[1]), .error(er[1])
  );

  // Decode by searching for the binary value whose Gray code matches.
  function automatic int g2b(int g, int w);
    for (int n = 0; n < (1 << w); n++) begin
      if ((n ^ (n >> 1)) == g) return n;
    end
    return -1;
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      synced[k] = 0;
      last[k]   = 0;
      merr[k]   = 0;
      pend[k]   = 0;
      pend_g[k] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock edge of the reference: finish the sample taken last edge,
  // then apply err_clear, then take this edge's sample.
  task automatic model_edge(int k, bit e, int gv, bit c);
    bit is_err;
    exp_t x;
    int b, m, d, f;
    is_err = 0;
    if (pend[k]) begin
      m = 1 << W[k];
      b = g2b(pend_g[k], W[k]);
      d = (b - last[k] + m) % m;
      f = 0;
      if (synced[k]) begin
        if (d == 0)          f = 3;
        else if (d == 1)     f = 1;
        else if (d == m - 1) f = 2;
        else begin
          f = 4;
          is_err = 1;
          merr[k] = 1;
        end
      end
      synced[k] = 1;
      last[k] = b;
      x.bin = b;
      x.fl  = f;
      x.due = cyc_cnt;
      if (k == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
    if (c && !is_err) begin
      merr[k] = 0;
      synced[k] = 0;
    end
    pend[k] = e;
    if (e) pend_g[k] = gv;
  endtask

  task automatic step(int k, bit e, int gv, bit c);
    en_s[k]    = e;
    clr_s[k]   = c;
    en_s[1-k]  = 1'b0;
    clr_s[1-k] = 1'b0;
    if (k == 0) gin0 = gv[1:0];
    else        gin1 = gv[2:0];
    @(posedge clk);
    #1;
    model_edge(k, e, gv, c);
    model_edge(1 - k, 1'b0, 0, 1'b0);
  endtask

  task automatic idle(int k, int n);
    for (int i = 0; i < n; i++) step(k, 1'b0, 0, 1'b0);
  endtask

  task automatic chk_zero(string tag);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (vld[k] || up[k] || dn[k] || hd[k] || se[k] || er[k] ||
          (k == 0 ? int'(bin0) : int'(bin1)) != 0) begin
        n_fail++;
        $display("FAIL %s inst%0d: outputs not all zero (v=%b u=%b d=%b h=%b s=%b e=%b)",
                 tag, k, vld[k], up[k], dn[k], hd[k], se[k], er[k]);
      end
    end
  endtask

  task automatic chk(int k, int b);
    exp_t x;
    int fl, nset;
    nset = int'(up[k]) + int'(dn[k]) + int'(hd[k]) + int'(se[k]);
    fl = up[k] ? 1 : dn[k] ? 2 : hd[k] ? 3 : se[k] ? 4 : 0;
    if (nset > 1) fl = 9;
    n_chk++;
    if (er[k] !== merr[k]) begin
      n_fail++;
      $display("FAIL error inst%0d cyc%0d: got %b want %b", k, cyc_cnt, er[k], merr[k]);
    end
    n_chk++;
    if (b != last[k]) begin
      n_fail++;
      $display("FAIL bin_out inst%0d cyc%0d: got %0d want %0d", k, cyc_cnt, b, last[k]);
    end
    if (vld[k]) begin
      n_chk++;
      if (qsize(k) == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid inst%0d cyc%0d: got valid want none", k, cyc_cnt);
      end else begin
        x = (k == 0) ? q0.pop_front() : q1.pop_front();
        if (x.bin != b || x.fl != fl || x.due != cyc_cnt) begin
          n_fail++;
          $display("FAIL sample inst%0d cyc%0d: got bin=%0d fl=%0d cyc=%0d want bin=%0d fl=%0d cyc=%0d",
                   k, cyc_cnt, b, fl, cyc_cnt, x.bin, x.fl, x.due);
        end
      end
    end else begin
      n_chk++;
      if (nset != 0) begin
        n_fail++;
        $display("FAIL idle_flags inst%0d cyc%0d: got %0d flags want 0", k, cyc_cnt, nset);
      end
      if (qsize(k) > 0) begin
        x = (k == 0) ? q0[0] : q1[0];
        if (x.due < cyc_cnt) begin
          n_fail++;
          $display("FAIL missing_valid inst%0d cyc%0d: got none want bin=%0d", k, cyc_cnt, x.bin);
          if (k == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (not_reset) begin
      chk(0, int'(bin0));
      chk(1, int'(bin1));
    end
  end

  int gseq [$];
  int cur [2];
  int nb, r;

  initial begin
    not_reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en_s[k] = 1'b0;
      clr_s[k] = 1'b0;
    end
    gin0 = '0;
    gin1 = '0;
    model_reset();
    #3;
    chk_zero("reset");
    @(posedge clk);
    #2;
    not_reset = 1'b1;

    // WIDTH=2 counting up with wrap 3 -> 0
    gseq = '{0, 1, 3, 2, 0};
    foreach (gseq[i]) step(0, 1'b1, gseq[i], 1'b0);
    idle(0, 3);
    step(0, 1'b0, 0, 1'b1);
    idle(0, 1);

    // WIDTH=2 counting down with wrap 0 -> 3
    gseq = '{0, 2, 3, 1, 0};
    foreach (gseq[i]) step(0, 1'b1, gseq[i], 1'b0);
    idle(0, 3);
    step(0, 1'b0, 0, 1'b1);
    idle(0, 1);

    // gapped strobe
    step(0, 1'b1, 0, 1'b0);
    idle(0, 2);
    step(0, 1'b1, 1, 1'b0);
    idle(0, 1);
    step(0, 1'b1, 3, 1'b0);
    idle(0, 4);

    // WIDTH=3: up, hold, illegal jump 1 -> 5
    step(1, 1'b0, 0, 1'b1);
    gseq = '{0, 1, 1, 7};
    foreach (gseq[i]) step(1, 1'b1, gseq[i], 1'b0);
    idle(1, 10);
    step(1, 1'b0, 0, 1'b1);
    step(1, 1'b1, 7, 1'b0);
    step(1, 1'b1, 5, 1'b0);
    idle(1, 3);

    // clear on the same edge that classifies an error
    step(1, 1'b1, 0, 1'b0);
    step(1, 1'b1, 7, 1'b0);
    step(1, 1'b1, 0, 1'b0);
    step(1, 1'b0, 0, 1'b1);
    idle(1, 3);
    step(1, 1'b1, 1, 1'b0);
    idle(1, 3);

    // reset while a sample sits in stage 1
    step(1, 1'b1, 2, 1'b0);
    #2;
    not_reset = 1'b0;
    #1;
    chk_zero("reset_inflight");
    model_reset();
    not_reset = 1'b1;
    idle(1, 3);
    step(1, 1'b1, 6, 1'b0);
    step(1, 1'b1, 2, 1'b0);
    idle(1, 3);

    // randomized streams, mostly legal steps
    for (int k = 0; k < 2; k++) begin
      cur[k] = last[k];
      for (int i = 0; i < 300; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 70) nb = (cur[k] + int'($urandom_range(0, 2)) - 1 + (1 << W[k])) % (1 << W[k]);
        else        nb = int'($urandom_range(0, (1 << W[k]) - 1));
        cur[k] = nb;
        step(k, ($urandom_range(0, 3) != 0), nb ^ (nb >> 1), ($urandom_range(0, 19) == 0));
      end
      idle(k, 4);
    end

    idle(0, 2);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (qsize(k) != 0) begin
        n_fail++;
        $display("FAIL drain inst%0d: got %0d pending want 0", k, qsize(k));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
